// File: rtl/hamming_rx_decoder.sv
// Serial Hamming(7,4) receiver: deserialises 8 codewords per 32-bit word, corrects single errors.
// Define HAMMING_RX_SECDED_EN for extended (8,4) codewords with double-error detection.
module hamming_rx_decoder (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        data_in,
    input  logic        data_valid,
    output logic        data_in_ready,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [3:0]  corr_cnt,
    output logic        uncorr_err
);
`ifdef HAMMING_RX_SECDED_EN
    localparam int CW_BITS = 8;
`else
    localparam int CW_BITS = 7;
`endif
    localparam int NIBBLES = 8;

    typedef enum logic {RECV, HOLD} state_t;

    state_t               state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [2:0]           nib_cnt_q, nib_cnt_d;
    logic [CW_BITS-2:0]   sr_q, sr_d;
    logic [31:0]          acc_q, acc_d;
    logic [3:0]           tally_corr_q, tally_corr_d;
    logic                 tally_unc_q, tally_unc_d;
    logic [31:0]          word_out_q, word_out_d;
    logic                 word_valid_q, word_valid_d;
    logic [3:0]           corr_cnt_q, corr_cnt_d;
    logic                 uncorr_q, uncorr_d;
    logic                 ready_q, ready_d;

    // Full codeword as seen on the last bit; cw[i] holds position i+1.
    logic [CW_BITS-1:0]   cw;
    logic [2:0]           syn;
    logic [6:0]           fixed;
    logic                 flip_en, cw_corr, cw_dbl;
    logic [3:0]           nib;

    assign cw  = {data_in, sr_q};
    assign syn = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                  cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                  cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};

    always_comb begin
        flip_en = (syn != 3'd0);
        cw_corr = (syn != 3'd0);
        cw_dbl  = 1'b0;
`ifdef HAMMING_RX_SECDED_EN
        // Overall parity distinguishes single errors from uncorrectable doubles.
        if (syn != 3'd0 && !(^cw)) begin
            flip_en = 1'b0;
            cw_corr = 1'b0;
            cw_dbl  = 1'b1;
        end else if (syn == 3'd0 && (^cw)) begin
            cw_corr = 1'b1;
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_fix
            assign fixed[gi] = cw[gi] ^ (flip_en && (syn == 3'(gi + 1)));
        end
    endgenerate

    assign nib = {fixed[2], fixed[4], fixed[5], fixed[6]};

    logic        accept, drain, last_bit, last_nib;
    logic [31:0] acc_next;
    logic [3:0]  corr_next;
    logic        unc_next;

    assign accept    = data_valid && ready_q;
    assign drain     = word_valid_q && word_ready;
    assign last_bit  = (bit_cnt_q == 3'(CW_BITS - 1));
    assign last_nib  = (nib_cnt_q == 3'(NIBBLES - 1));
    assign acc_next  = {acc_q[27:0], nib};
    assign corr_next = tally_corr_q + {3'd0, cw_corr};
    assign unc_next  = tally_unc_q | cw_dbl;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        nib_cnt_d    = nib_cnt_q;
        sr_d         = sr_q;
        acc_d        = acc_q;
        tally_corr_d = tally_corr_q;
        tally_unc_d  = tally_unc_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_d     = uncorr_q;
        ready_d      = ready_q;

        if (drain)
            word_valid_d = 1'b0;

        case (state_q)
            RECV: begin
                if (accept) begin
                    if (!last_bit) begin
                        sr_d      = {data_in, sr_q[CW_BITS-2:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        bit_cnt_d = 3'd0;
                        if (!last_nib) begin
                            nib_cnt_d    = nib_cnt_q + 3'd1;
                            acc_d        = acc_next;
                            tally_corr_d = corr_next;
                            tally_unc_d  = unc_next;
                        end else begin
                            nib_cnt_d = 3'd0;
                            if (!word_valid_q || drain) begin
                                word_out_d   = acc_next;
                                corr_cnt_d   = corr_next;
                                uncorr_d     = unc_next;
                                word_valid_d = 1'b1;
                                acc_d        = 32'd0;
                                tally_corr_d = 4'd0;
                                tally_unc_d  = 1'b0;
                            end else begin
                                // Output still occupied: park the finished word and stall input.
                                acc_d        = acc_next;
                                tally_corr_d = corr_next;
                                tally_unc_d  = unc_next;
                                state_d      = HOLD;
                                ready_d      = 1'b0;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (drain) begin
                    word_out_d   = acc_q;
                    corr_cnt_d   = tally_corr_q;
                    uncorr_d     = tally_unc_q;
                    word_valid_d = 1'b1;
                    acc_d        = 32'd0;
                    tally_corr_d = 4'd0;
                    tally_unc_d  = 1'b0;
                    state_d      = RECV;
                    ready_d      = 1'b1;
                end
            end
            default: begin
                state_d = RECV;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q      <= RECV;
            bit_cnt_q    <= 3'd0;
            nib_cnt_q    <= 3'd0;
            sr_q         <= '0;
            acc_q        <= 32'd0;
            tally_corr_q <= 4'd0;
            tally_unc_q  <= 1'b0;
            word_out_q   <= 32'd0;
            word_valid_q <= 1'b0;
            corr_cnt_q   <= 4'd0;
            uncorr_q     <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            nib_cnt_q    <= nib_cnt_d;
            sr_q         <= sr_d;
            acc_q        <= acc_d;
            tally_corr_q <= tally_corr_d;
            tally_unc_q  <= tally_unc_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_q     <= uncorr_d;
            ready_q      <= ready_d;
        end
    end

    assign data_in_ready = ready_q;
    assign word_out      = word_out_q;
    assign word_valid    = word_valid_q;
    assign corr_cnt      = corr_cnt_q;
    assign uncorr_err    = uncorr_q;
endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Bench for hamming_rx_decoder: directed and random words against a nearest-codeword reference model.
module tb_hamming_rx_decoder;
`ifdef HAMMING_RX_SECDED_EN
    localparam int CW = 8;
    localparam logic [7:0] MASK = 8'hFF;
`else
    localparam int CW = 7;
    localparam logic [7:0] MASK = 8'h7F;
`endif

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        data_in = 1'b0;
    logic        data_valid = 1'b0;
    logic        word_ready = 1'b1;
    logic        data_in_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic [3:0]  corr_cnt;
    logic        uncorr_err;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    int got_rd = 0;
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    hamming_rx_decoder dut (
        .clk_in(clk_in), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_in_ready(data_in_ready), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .corr_cnt(corr_cnt), .uncorr_err(uncorr_err)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (word_valid) valid_cycles++;
        if (word_valid && word_ready) got_q.push_back({word_out, corr_cnt, uncorr_err});
    end

    // Codeword for a nibble, bit i = position i+1; bit 7 is overall even parity.
    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] c;
        c[0] = n[3] ^ n[2] ^ n[0];
        c[1] = n[3] ^ n[1] ^ n[0];
        c[2] = n[3];
        c[3] = n[2] ^ n[1] ^ n[0];
        c[4] = n[2];
        c[5] = n[1];
        c[6] = n[0];
        c[7] = ^c[6:0];
        return c;
    endfunction

    // Decode by exhaustive nearest-codeword search over all 16 nibbles.
    function automatic void ref_decode(input logic [7:0] rx, output logic [3:0] nib,
                                       output logic [3:0] corr, output logic unc);
        int best = 99;
        logic [3:0] bn = 4'd0;
        for (int n = 0; n < 16; n++) begin
            int d;
            d = $countones((enc(4'(n)) ^ rx) & MASK);
            if (d < best) begin
                best = d;
                bn = 4'(n);
            end
        end
        nib = bn;
        corr = 4'd0;
        unc = 1'b0;
        if (best == 1) corr = 4'd1;
        else if (best >= 2) begin
            nib = {rx[2], rx[4], rx[5], rx[6]};
            unc = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int guard = 0;
        data_in = b;
        data_valid = 1'b1;
        while (data_in_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) chk("in_ready_timeout", 64'(data_in_ready), 64'd1);
        tick();
        data_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [63:0] err, input int nbits,
                             input int gap_max, input bit push);
        logic [31:0] ew = 32'd0;
        logic [3:0]  ec = 4'd0;
        logic        eu = 1'b0;
        logic [3:0]  rn, rc;
        logic        ru;
        logic [7:0]  c;
        int sent = 0;
        for (int k = 0; k < 8; k++) begin
            c = (enc(w[31-4*k -: 4]) ^ err[8*k +: 8]) & MASK;
            ref_decode(c, rn, rc, ru);
            ew = {ew[27:0], rn};
            ec = ec + rc;
            eu = eu | ru;
            for (int p = 0; p < CW; p++) begin
                if (sent < nbits) begin
                    repeat ($urandom_range(0, gap_max)) begin
                        data_in = 1'($urandom);
                        tick();
                    end
                    send_bit(c[p]);
                    sent++;
                end
            end
        end
        if (push) exp_q.push_back({ew, ec, eu});
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    task automatic check_words(input string tag);
        logic [36:0] e;
        chk({tag, "_count"}, 64'(got_q.size() - got_rd), 64'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_rd < got_q.size()) begin
                chk(tag, 64'(got_q[got_rd]), 64'(e));
                got_rd++;
            end
        end
        got_rd = got_q.size();
    endtask

    initial begin
        int base;
        logic [63:0] err;
        logic [31:0] wa, wb;

        repeat (3) tick();
        rst = 1'b1;
        chk("rst_word_valid", 64'(word_valid), 64'd0);
        chk("rst_word_out", 64'(word_out), 64'd0);
        chk("rst_corr_cnt", 64'(corr_cnt), 64'd0);
        chk("rst_uncorr", 64'(uncorr_err), 64'd0);
        chk("rst_in_ready", 64'(data_in_ready), 64'd1);

        // Clean word; exact value also fixed independently of the model.
        base = valid_cycles;
        send_word(32'h79A1E714, 64'd0, 999, 0, 1);
        chk("clean_word_direct", 64'(word_out), 64'h79A1E714);
        drain();
        check_words("clean");
        chk("clean_valid_cycles", 64'(valid_cycles - base), 64'd1);

        send_word(32'h79A1E714, 64'h10, 999, 0, 1);
        chk("pos5_corr_direct", 64'(corr_cnt), 64'd1);
        chk("pos5_word_direct", 64'(word_out), 64'h79A1E714);
        drain();
        check_words("pos5");

        err = 64'h01_40_20_10_08_04_02_01;
        send_word(32'h79A1E714, err, 999, 0, 1);
        chk("all8_corr_direct", 64'(corr_cnt), 64'd8);
        chk("all8_word_direct", 64'(word_out), 64'h79A1E714);
        drain();
        check_words("all8");

`ifdef HAMMING_RX_SECDED_EN
        send_word(32'h79A1E714, 64'h22, 999, 0, 1);
        chk("dbl_uncorr_direct", 64'(uncorr_err), 64'd1);
        chk("dbl_corr_direct", 64'(corr_cnt), 64'd0);
        drain();
        check_words("dbl");
`endif

        // Backpressure: two words buffered, input stalls on the second.
        wa = $urandom;
        wb = $urandom | 32'h1;
        word_ready = 1'b0;
        send_word(wa, 64'd0, 999, 0, 1);
        chk("bp_first_valid", 64'(word_valid), 64'd1);
        chk("bp_first_word", 64'(word_out), 64'(wa));
        send_word(wb, 64'h0400, 999, 0, 1);
        chk("bp_ready_low", 64'(data_in_ready), 64'd0);
        chk("bp_first_held", 64'(word_out), 64'(wa));
        repeat (5) tick();
        chk("bp_still_stalled", 64'(data_in_ready), 64'd0);
        chk("bp_corr_held", 64'(corr_cnt), 64'd0);
        word_ready = 1'b1;
        drain();
        chk("bp_ready_back", 64'(data_in_ready), 64'd1);
        check_words("bp_order");

        // Reset part-way through a word; the partial word must vanish.
        send_word(32'hDEADBEEF, 64'd0, 20, 0, 0);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(word_valid), 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        got_rd = got_q.size();
        base = valid_cycles;
        chk("midrst_word_out", 64'(word_out), 64'd0);
        chk("midrst_in_ready", 64'(data_in_ready), 64'd1);
        send_word(32'h00000000, 64'd0, 999, 0, 1);
        drain();
        check_words("midrst_zero");
        chk("midrst_valid_cycles", 64'(valid_cycles - base), 64'd1);

        // Random words with random errors and input gaps.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] w;
            w = $urandom;
            err = 64'd0;
            for (int k = 0; k < 8; k++) begin
                int r, p1, p2;
                r = $urandom_range(0, 3);
                p1 = $urandom_range(0, CW - 1);
                p2 = (p1 + $urandom_range(1, CW - 1)) % CW;
                if (r >= 2) err[8*k + p1] = 1'b1;
`ifdef HAMMING_RX_SECDED_EN
                if (r == 3) err[8*k + p2] = 1'b1;
`endif
            end
            send_word(w, err, 999, (i % 3 == 0) ? 2 : 0, 1);
            if (i % 4 == 3) begin
                drain();
                check_words("random");
            end
        end
        drain();
        check_words("random_tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
